// File: rtl/currctrl_regbank_scanner.sv
// Control-loop side master for port s2 of the CurrCTRL register RAM: on each trigger it
// snapshots status words into RAM, reads back the setpoint window and commits it atomically.
module currctrl_regbank_scanner #(
  parameter int unsigned ADDR_W       = 8,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned SP_BASE      = 0,
  parameter int unsigned SP_COUNT     = 8,
  parameter int unsigned ST_BASE      = 128,
  parameter int unsigned ST_COUNT     = 8,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         trigger,
  input  logic [ST_COUNT*DATA_W-1:0]   st_in,
  output logic [SP_COUNT*DATA_W-1:0]   sp_out,
  output logic                         busy,
  output logic                         done,
  output logic [7:0]                   overrun_cnt,
  output logic [ADDR_W-1:0]            avm_address,
  output logic                         avm_chipselect,
  output logic                         avm_write,
  output logic [DATA_W/8-1:0]          avm_byteenable,
  output logic [DATA_W-1:0]            avm_writedata,
  input  logic [DATA_W-1:0]            avm_readdata
);

  localparam int unsigned MaxAB  = (ST_COUNT > SP_COUNT) ? ST_COUNT : SP_COUNT;
  localparam int unsigned MaxCnt = (MaxAB > READ_LATENCY) ? MaxAB : READ_LATENCY;
  localparam int unsigned CntW   = (MaxCnt > 1) ? $clog2(MaxCnt) : 1;

  if (SP_COUNT == 0 || ST_COUNT == 0 || READ_LATENCY == 0) begin : g_bad_count
    $error("currctrl_regbank_scanner: SP_COUNT, ST_COUNT and READ_LATENCY must be >= 1");
  end
  if ((longint'(SP_BASE) + longint'(SP_COUNT) > (longint'(1) << ADDR_W)) ||
      (longint'(ST_BASE) + longint'(ST_COUNT) > (longint'(1) << ADDR_W))) begin : g_bad_range
    $error("currctrl_regbank_scanner: setpoint or status window exceeds the address space");
  end

  typedef enum logic [2:0] {StIdle, StSnap, StWrite, StRead, StDrain, StCommit} state_e;

  state_e                       state_q, state_d;
  logic [CntW-1:0]              idx_q, idx_d;
  logic                         pending_q, pending_d;
  logic [7:0]                   ovr_q, ovr_d;
  logic [ST_COUNT*DATA_W-1:0]   st_shadow_q;
  logic [SP_COUNT*DATA_W-1:0]   sp_shadow_q, sp_shadow_d, sp_out_q;
  logic                         rd_issue;
  // Issue-index pipeline: entry LAT-1 names the setpoint word whose data is on readdata now.
  logic                         rd_vld_q [READ_LATENCY];
  logic [CntW-1:0]              rd_idx_q [READ_LATENCY];

  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    pending_d      = pending_q;
    ovr_d          = ovr_q;
    busy           = 1'b0;
    done           = 1'b0;
    avm_chipselect = 1'b0;
    avm_write      = 1'b0;
    avm_address    = '0;
    avm_writedata  = '0;
    rd_issue       = 1'b0;

    if (trigger && state_q != StIdle) begin
      if (!pending_q) begin
        pending_d = 1'b1;
      end else if (ovr_q != 8'hFF) begin
        ovr_d = ovr_q + 8'd1;
      end
    end

    unique case (state_q)
      StIdle: begin
        if (trigger || pending_q) begin
          state_d   = StSnap;
          pending_d = 1'b0;
        end
      end
      StSnap: begin
        busy    = 1'b1;
        idx_d   = '0;
        state_d = StWrite;
      end
      StWrite: begin
        busy           = 1'b1;
        avm_chipselect = 1'b1;
        avm_write      = 1'b1;
        avm_address    = ADDR_W'(ST_BASE) + ADDR_W'(idx_q);
        avm_writedata  = st_shadow_q[int'(idx_q)*DATA_W +: DATA_W];
        if (idx_q == CntW'(ST_COUNT - 1)) begin
          idx_d   = '0;
          state_d = StRead;
        end else begin
          idx_d = idx_q + CntW'(1);
        end
      end
      StRead: begin
        busy           = 1'b1;
        avm_chipselect = 1'b1;
        avm_address    = ADDR_W'(SP_BASE) + ADDR_W'(idx_q);
        rd_issue       = 1'b1;
        if (idx_q == CntW'(SP_COUNT - 1)) begin
          idx_d   = '0;
          state_d = StDrain;
        end else begin
          idx_d = idx_q + CntW'(1);
        end
      end
      StDrain: begin
        busy = 1'b1;
        if (idx_q == CntW'(READ_LATENCY - 1)) begin
          idx_d   = '0;
          state_d = StCommit;
        end else begin
          idx_d = idx_q + CntW'(1);
        end
      end
      StCommit: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    avm_byteenable = {(DATA_W/8){avm_chipselect}};
  end

  always_comb begin
    sp_shadow_d = sp_shadow_q;
    if (rd_vld_q[READ_LATENCY-1]) begin
      sp_shadow_d[int'(rd_idx_q[READ_LATENCY-1])*DATA_W +: DATA_W] = avm_readdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      pending_q   <= 1'b0;
      ovr_q       <= '0;
      st_shadow_q <= '0;
      sp_shadow_q <= '0;
      sp_out_q    <= '0;
      for (int i = 0; i < int'(READ_LATENCY); i++) begin
        rd_vld_q[i] <= 1'b0;
        rd_idx_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      pending_q   <= pending_d;
      ovr_q       <= ovr_d;
      sp_shadow_q <= sp_shadow_d;
      if (state_q == StSnap) st_shadow_q <= st_in;
      // Commit takes the last captured word directly so sp_out moves in the done cycle.
      if (state_q == StDrain && state_d == StCommit) sp_out_q <= sp_shadow_d;
      rd_vld_q[0] <= rd_issue;
      rd_idx_q[0] <= idx_q;
      for (int i = 1; i < int'(READ_LATENCY); i++) begin
        rd_vld_q[i] <= rd_vld_q[i-1];
        rd_idx_q[i] <= rd_idx_q[i-1];
      end
    end
  end

  assign sp_out      = sp_out_q;
  assign overrun_cnt = ovr_q;

endmodule
